data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Responder end of the core's data memory interface. Accepts mem_ren/mem_wen/mem_addr/mem_dout from the pipeline core, performs the access on an internal word-addressed RAM, and returns mem_din.
- Models a multi-cycle memory with a programmable wait-state counter. Asserts mem_stall so the core holds its request. Flags misaligned, out-of-range and conflicting requests on mem_err.
- Sits beside the core in the top level, in place of an ideal single-cycle data RAM.

Parameters:
- ADDR_WIDTH, 10, log2 of RAM depth in 32-bit words (1024 words = 4 KiB).
- WAIT_CYCLES, 2, number of BUSY cycles per access; legal range 1..15.
- BASE_ADDR, 32'h0000_0000, byte base address of the RAM window; aligned to 4<<ADDR_WIDTH.

Ports:
- clk  input  1  main clock.
- rst  input  1  reset, asynchronous, active-high.
- mem_ren  input  1  read request from core.
- mem_wen  input  1  write request from core.
- mem_addr  input  32  byte address from core.
- mem_dout  input  32  write data from core.
- mem_din  output  32  read data to core, registered.
- mem_stall  output  1  core must hold its request and freeze while high.
- mem_err  output  1  one-cycle error pulse for the current request.

Behaviour:
- One clock (clk). rst is asynchronous and active-high. Reset state: IDLE. mem_din=0, mem_err=0, internal counter=0. mem_stall is forced 0 while rst is high. RAM contents are not reset.
- req = mem_ren | mem_wen.
- State IDLE:
  - On req, latch addr, data, ren and wen.
  - Set err_kind if any of: addr[1:0]!=0; addr[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2]; mem_ren&mem_wen.
  - err set -> go to RESP with err flag. Otherwise -> go to BUSY with cnt=WAIT_CYCLES-1.
- State BUSY:
  - cnt decrements each cycle.
  - When cnt==0: perform the access at the clock edge and go to RESP.
  - Write: ram[idx] <= latched data. Read: mem_din <= ram[idx]. idx = addr[ADDR_WIDTH+1:2].
- State RESP (exactly one cycle):
  - mem_stall=0. mem_err=1 iff error.
  - The core request still present in this cycle is the completed one and is ignored. Next state is always IDLE.
- mem_stall is combinational: 1 in IDLE while req is present, and 1 throughout BUSY; 0 in RESP and in IDLE with no req.
- Latency:
  - Valid request: accepted at cycle 0, BUSY for cycles 1..WAIT_CYCLES, RESP at cycle WAIT_CYCLES+1. mem_stall high for WAIT_CYCLES+1 cycles.
  - Error request: accepted at cycle 0, RESP at cycle 1. mem_stall high 1 cycle.
- mem_din holds the last successful read value. It is unchanged by writes and errors; on an error read it keeps its prior value.
- Requests are latched at acceptance. Changes or deassertion of core inputs during BUSY are ignored; the transaction completes with the latched values.
- Back-to-back requests: IDLE follows RESP, so sustained throughput is one access per WAIT_CYCLES+2 cycles.
- Reset mid-BUSY: return to IDLE immediately. A pending write is dropped; the RAM is untouched for that transaction.
- mem_err is registered: asserted only in RESP, never in IDLE or BUSY.

Decomposition:
- Shared package mem_pkg:
  - state encoding: IDLE=2'd0, BUSY=2'd1, RESP=2'd2;
  - error-kind codes: ERR_ALIGN, ERR_RANGE, ERR_CONFLICT (kept internal, available for debug);
  - WAIT_CYCLES_MAX=15.
- Sub-module data_ram_sp: single-port synchronous RAM, depth 2**ADDR_WIDTH x 32, with we, idx, wdata and registered rdata. Instantiated once.
- The FSM, counter and checks live in data_mem_responder.

Test Plan:
- Reset released, write 32'hDEAD_BEEF to 0x0000_0010 with WAIT_CYCLES=2 -> mem_stall high for 3 cycles, RESP in cycle 3, mem_err=0. A following read of 0x10 returns mem_din=32'hDEAD_BEEF in its RESP cycle.
- Read of 0x0000_0013 (misaligned) -> mem_stall high 1 cycle, mem_err=1 in cycle 1, mem_din unchanged, RAM unchanged.
- Read of 0x0000_1000 with ADDR_WIDTH=10 (out of range) -> mem_err=1 in cycle 1. mem_ren&mem_wen together at a valid address -> mem_err=1, no write.
- Back-to-back: write A=0x4 := 1, write B=0x8 := 2, read A, read B with the core holding each request while stalled -> each request takes 4 cycles, reads return 1 then 2, and no request is serviced twice.
- Core changes mem_addr and mem_dout during BUSY of a write to 0x20 -> data latched at acceptance lands at 0x20; the new address is unaffected.
- Assert rst during BUSY of a write 0x30 := 32'h1234 -> outputs return to reset values asynchronously. A subsequent read of 0x30 returns the prior contents, not 32'h1234.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_pkg: shared types and constants for the data memory responder.    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_ALIGN    = 2'd1,
    ERR_RANGE    = 2'd2,
    ERR_CONFLICT = 2'd3
  } err_kind_t;

  localparam int WAIT_CYCLES_MAX = 15;
  localparam int CNT_W           = 4;

endpackage
`default_nettype wire

// File: rtl/data_ram_sp.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | data_ram_sp: single-port synchronous 32-bit RAM, registered read.     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module data_ram_sp #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] ram_q [2**ADDR_WIDTH];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  // Array storage is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (we) begin
      ram_q[idx] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = ram_q[idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= 32'h0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | data_mem_responder: multi-cycle data memory slave with wait states.   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        mem_err
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    ren_q, ren_d;
  logic                    wen_q, wen_d;
  logic                    err_q, err_d;
  logic                    req;
  err_kind_t               err_kind;
  logic                    ram_we;
  logic                    ram_re;

  assign req = mem_ren | mem_wen;

  always_comb begin
    err_kind = ERR_NONE;
    if (mem_ren && mem_wen) begin
      err_kind = ERR_CONFLICT;
    end else if (mem_addr[1:0] != 2'b00) begin
      err_kind = ERR_ALIGN;
    end else if (mem_addr[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2]) begin
      err_kind = ERR_RANGE;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    err_d   = 1'b0;
    ram_we  = 1'b0;
    ram_re  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          idx_d   = mem_addr[ADDR_WIDTH+1:2];
          wdata_d = mem_dout;
          ren_d   = mem_ren;
          wen_d   = mem_wen;
          if (err_kind != ERR_NONE) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          ram_we  = wen_q;
          ram_re  = ren_q;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      // The core still presents the finished request here; it is not re-accepted.
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      err_q   <= err_d;
    end
  end

  assign mem_stall = !rst && (((state_q == IDLE) && req) || (state_q == BUSY));
  assign mem_err   = err_q;

  data_ram_sp #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .re    (ram_re),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (mem_din)
  );

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_data_mem_responder: scoreboard bench for data_mem_responder.       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_ren = 1'b0;
  logic        mem_wen = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_dout = 32'h0;
  logic [31:0] mem_din;
  logic        mem_stall;
  logic        mem_err;

  typedef struct {
    bit          err;
    logic [31:0] din;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   mon_lat = 0;

  data_mem_responder #(
    .ADDR_WIDTH  (10),
    .WAIT_CYCLES (2),
    .BASE_ADDR   (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .mem_din   (mem_din),
    .mem_stall (mem_stall),
    .mem_err   (mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Response is the cycle where the core still requests but stall is low.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      mon_lat = 0;
    end else if (mem_ren || mem_wen) begin
      if (mem_stall) begin
        mon_lat++;
        check("err_while_stalled", {31'h0, mem_err}, 32'h0);
      end else begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_response: got response expected none");
        end else begin
          e = exp_q.pop_front();
          check("resp_err", {31'h0, mem_err}, {31'h0, e.err});
          check("resp_din", mem_din, e.din);
          check("resp_stall_cycles", mon_lat, e.lat);
        end
        mon_lat = 0;
      end
    end else begin
      mon_lat = 0;
      check("err_when_idle", {31'h0, mem_err}, 32'h0);
    end
  end

  task automatic do_req(input bit ren, input bit wen, input logic [31:0] addr,
                        input logic [31:0] data, input bit mutate, input bit exp_err,
                        input logic [31:0] exp_din, input int exp_lat);
    int n;
    bit done;
    exp_q.push_back('{exp_err, exp_din, exp_lat});
    @(posedge clk);
    #2;
    mem_ren  = ren;
    mem_wen  = wen;
    mem_addr = addr;
    mem_dout = data;
    n = 0;
    done = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      if (!mem_stall) begin
        done = 1;
      end else begin
        n++;
        if (mutate && n == 1) begin
          @(posedge clk);
          #2;
          mem_addr = addr + 32'h4;
          mem_dout = 32'h0BAD_0BAD;
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: got stall stuck expected release within 20 cycles");
    end
  endtask

  initial begin
    #1;
    check("reset_din", mem_din, 32'h0);
    check("reset_err", {31'h0, mem_err}, 32'h0);
    mem_ren = 1'b1;
    #1;
    check("reset_stall_forced", {31'h0, mem_stall}, 32'h0);
    mem_ren = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_req(0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 32'h0,         3);
    do_req(1, 0, 32'h0000_0010, 32'h0,         0, 0, 32'hDEAD_BEEF, 3);
    do_req(1, 0, 32'h0000_0013, 32'h0,         0, 1, 32'hDEAD_BEEF, 1);
    do_req(1, 0, 32'h0000_1000, 32'h0,         0, 1, 32'hDEAD_BEEF, 1);
    do_req(1, 1, 32'h0000_0010, 32'h5555_5555, 0, 1, 32'hDEAD_BEEF, 1);
    do_req(0, 1, 32'h0000_0012, 32'h0,         0, 1, 32'hDEAD_BEEF, 1);
    do_req(1, 0, 32'h0000_0010, 32'h0,         0, 0, 32'hDEAD_BEEF, 3);

    do_req(0, 1, 32'h0000_0004, 32'h1,         0, 0, 32'hDEAD_BEEF, 3);
    do_req(0, 1, 32'h0000_0008, 32'h2,         0, 0, 32'hDEAD_BEEF, 3);
    do_req(1, 0, 32'h0000_0004, 32'h0,         0, 0, 32'h1,         3);
    do_req(1, 0, 32'h0000_0008, 32'h0,         0, 0, 32'h2,         3);

    do_req(0, 1, 32'h0000_0FFC, 32'hA5A5_5A5A, 0, 0, 32'h2,         3);
    do_req(1, 0, 32'h0000_0FFC, 32'h0,         0, 0, 32'hA5A5_5A5A, 3);

    do_req(0, 1, 32'h0000_0024, 32'h2424_2424, 0, 0, 32'hA5A5_5A5A, 3);
    do_req(0, 1, 32'h0000_0020, 32'h2020_2020, 1, 0, 32'hA5A5_5A5A, 3);
    do_req(1, 0, 32'h0000_0020, 32'h0,         0, 0, 32'h2020_2020, 3);
    do_req(1, 0, 32'h0000_0024, 32'h0,         0, 0, 32'h2424_2424, 3);

    do_req(0, 1, 32'h0000_0030, 32'hCAFE_0030, 0, 0, 32'h2424_2424, 3);

    // Interrupt a write while it sits in BUSY.
    @(posedge clk);
    #2;
    mem_ren  = 1'b0;
    mem_wen  = 1'b1;
    mem_addr = 32'h0000_0030;
    mem_dout = 32'h0000_1234;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midbusy_rst_stall", {31'h0, mem_stall}, 32'h0);
    check("midbusy_rst_din", mem_din, 32'h0);
    check("midbusy_rst_err", {31'h0, mem_err}, 32'h0);
    mem_wen = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_req(1, 0, 32'h0000_0030, 32'h0,         0, 0, 32'hCAFE_0030, 3);
    do_req(1, 0, 32'h0000_0031, 32'h0,         0, 1, 32'hCAFE_0030, 1);

    @(posedge clk);
    #2;
    mem_ren = 1'b0;
    mem_wen = 1'b0;
    repeat (3) @(negedge clk);
    check("pending_expectations", exp_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
